cr_iu_oper_sb: RTL and testbench
================================

# cr_iu_oper_sb

Parametrised operand-preparation and scoreboard unit for the IU execute stage. It tracks up to NUM_PEND outstanding long-latency writebacks (loads, multi-cycle MAD/divide) by destination register and tag. It selects each of NUM_RD source operands from the debug-override, completion-forward, WB-forward or GPR-read paths, and stalls issue with a valid/ready handshake when a source or destination is still pending. It sits between the GPR file read ports and the ALU/branch/LSU/MAD operand inputs.

## Interface
- NUM_RD, 2: source operand ports (1..4).
- NUM_PEND, 2: scoreboard entries (1..8).
- XLEN, 32: data width.
- TAGW, 3: tag width; must satisfy 2^TAGW >= NUM_PEND.

- forever_cpuclk  in  1  core clock; all state changes on its rising edge.
- iu_yy_xx_reg_rst_b  in  1  asynchronous active-low reset.
- rd_idx  in  NUM_RD*5  source register indices; port p occupies bits [5p+4:5p].
- gpr_rd_data  in  NUM_RD*XLEN  GPR read data, port-packed.
- had_wbbr_vld / had_wbbr_data  in  1 / XLEN  debug override for all ports.
- wb_fwd_en / wb_fwd_idx / wb_fwd_data  in  1 / 5 / XLEN  single-cycle WB forward.
- iss_vld  in  1  instruction presented for issue.
- iss_long  in  1  instruction allocates a scoreboard entry.
- iss_dst  in  5  destination register.
- iss_src_use  in  NUM_RD  per-port source valid.
- iss_rdy  out  1  issue accepted this cycle when iss_vld is also high.
- iss_tag  out  TAGW  tag of the allocated entry; valid with an accepted long issue.
- cmplt_vld / cmplt_tag / cmplt_data  in  1 / TAGW / XLEN  long-latency completion.
- oper_data  out  NUM_RD*XLEN  selected operands.
- sb_pend_cnt  out  TAGW+1  number of valid entries.
- sb_err  out  1  sticky flag for a completion to a non-valid tag.

## Operation
- Entry state: vld, idx[4:0]. The tag equals the entry number.
- Per-port operand priority, highest first:
  - rd_idx = 0 gives 0.
  - had_wbbr_vld gives had_wbbr_data.
  - Completion match (cmplt_vld, entry cmplt_tag valid, its idx = rd_idx) gives cmplt_data.
  - wb_fwd_en with wb_fwd_idx = rd_idx gives wb_fwd_data.
  - Otherwise gpr_rd_data.
- Port blocked: iss_src_use[p], rd_idx != 0, a valid entry holds that idx, and that entry is not completing this cycle.
- WAW blocked: iss_dst != 0 and a valid entry holds iss_dst that is not completing this cycle.
- Full blocked: iss_long and no free entry in the pre-completion free mask. An entry freed this cycle is not reusable until the next cycle.
- iss_rdy = !(any port blocked | WAW blocked | full blocked). The debug override does not bypass blocking.
- Allocation: when iss_vld & iss_rdy & iss_long, the lowest-numbered free entry is set vld=1, idx=iss_dst. iss_tag shows that entry number combinationally. iss_dst = 0 with iss_long allocates an entry, and that entry never blocks.
- Completion: cmplt_vld to a valid tag clears vld. To an invalid tag it is ignored and sets sb_err, which stays set until reset.
- sb_pend_cnt is the registered population count of vld.

## Timing
- Reset: all vld=0, sb_pend_cnt=0, sb_err=0, iss_tag=0. iss_rdy=1 when sources are unused.
- Operand select and iss_rdy are combinational from the inputs and current state, with zero latency.
- Allocation is visible (blocks dependent reads, counts) from the next cycle.
- Completion forwards in the same cycle. vld clears at the edge that ends that cycle.
- Allocate and complete in the same cycle to different entries: both take effect, and the count is unchanged.
- Reset asserted mid-operation clears all entries immediately, including while a completion or issue is in flight. Completions after reset to old tags set sb_err.

## Test plan
- Reset, then rd_idx={x3,x5}, gpr data {0x11,0x22}, no forwarding: oper_data={0x11,0x22}, iss_rdy=1, sb_pend_cnt=0.
- Long issue dst=x7, tag 0. Next cycle issue with src x7: iss_rdy=0. Then cmplt_vld tag0 data 0xDEADBEEF: iss_rdy=1 and the operand is 0xDEADBEEF in the same cycle. sb_pend_cnt goes 1 to 0.
- NUM_PEND=2: fill both entries. A third long issue gives iss_rdy=0. A completion of tag1 in the same cycle still gives iss_rdy=0. The next cycle allocates tag1.
- wb_fwd_en idx x4 data 0xA5 and had_wbbr_vld data 0x5A on a port reading x4: operand 0x5A. A port reading x0 returns 0.
- Long dst=x9 pending, then a non-long issue with dst=x9: iss_rdy=0 (WAW block) until the completion.
- cmplt_vld to tag 1 while the entry is invalid: sb_err=1 and stays 1. Assert reset mid-stream: all outputs return to their reset values.

Source files
------------

// File: rtl/cr_iu_oper_sb.sv
// IU execute operand select with a tag-indexed scoreboard for
// long-latency writebacks; stalls issue on pending src/dst.
module cr_iu_oper_sb #(
  parameter int NUM_RD   = 2,
  parameter int NUM_PEND = 2,
  parameter int XLEN     = 32,
  parameter int TAGW     = 3
) (
  input  logic                     forever_cpuclk,
  input  logic                     iu_yy_xx_reg_rst_b,
  input  logic [NUM_RD*5-1:0]      rd_idx,
  input  logic [NUM_RD*XLEN-1:0]   gpr_rd_data,
  input  logic                     had_wbbr_vld,
  input  logic [XLEN-1:0]          had_wbbr_data,
  input  logic                     wb_fwd_en,
  input  logic [4:0]               wb_fwd_idx,
  input  logic [XLEN-1:0]          wb_fwd_data,
  input  logic                     iss_vld,
  input  logic                     iss_long,
  input  logic [4:0]               iss_dst,
  input  logic [NUM_RD-1:0]        iss_src_use,
  output logic                     iss_rdy,
  output logic [TAGW-1:0]          iss_tag,
  input  logic                     cmplt_vld,
  input  logic [TAGW-1:0]          cmplt_tag,
  input  logic [XLEN-1:0]          cmplt_data,
  output logic [NUM_RD*XLEN-1:0]   oper_data,
  output logic [TAGW:0]            sb_pend_cnt,
  output logic                     sb_err
);

  logic [NUM_PEND-1:0]      vld_q, vld_d;
  logic [NUM_PEND-1:0][4:0] idx_q, idx_d;
  logic [TAGW:0]            cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic [NUM_PEND-1:0] cmp_hit;
  logic [NUM_PEND-1:0] live;
  logic                cmp_any;
  logic [4:0]          cmp_idx;
  logic [TAGW-1:0]     free_tag;
  logic                has_free;
  logic [NUM_RD-1:0]   src_blk;
  logic                waw_blk;
  logic                full_blk;
  logic                alloc;

  // Descending scan so the lowest free entry wins.
  always_comb begin
    cmp_hit  = '0;
    live     = '0;
    cmp_any  = 1'b0;
    cmp_idx  = '0;
    free_tag = '0;
    has_free = 1'b0;
    for (int e = NUM_PEND-1; e >= 0; e--) begin
      cmp_hit[e] = cmplt_vld && vld_q[e] &&
                   (cmplt_tag == TAGW'(e));
      live[e]    = vld_q[e] && !cmp_hit[e] &&
                   (idx_q[e] != 5'd0);
      if (cmp_hit[e]) begin
        cmp_any = 1'b1;
        cmp_idx = idx_q[e];
      end
      if (!vld_q[e]) begin
        has_free = 1'b1;
        free_tag = TAGW'(e);
      end
    end
  end

  // Entries for x0 are never live, so x0 reads/dst never block.
  always_comb begin
    src_blk = '0;
    waw_blk = 1'b0;
    for (int e = 0; e < NUM_PEND; e++) begin
      if (live[e] && idx_q[e] == iss_dst)
        waw_blk = 1'b1;
      for (int p = 0; p < NUM_RD; p++) begin
        if (live[e] && iss_src_use[p] &&
            idx_q[e] == rd_idx[5*p +: 5])
          src_blk[p] = 1'b1;
      end
    end
  end

  assign full_blk = iss_long && !has_free;
  assign iss_rdy  = !(|src_blk || waw_blk || full_blk);
  assign alloc    = iss_vld && iss_rdy && iss_long;
  assign iss_tag  = alloc ? free_tag : '0;

  always_comb begin
    oper_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_idx[5*p +: 5] == 5'd0)
        oper_data[p*XLEN +: XLEN] = '0;
      else if (had_wbbr_vld)
        oper_data[p*XLEN +: XLEN] = had_wbbr_data;
      else if (cmp_any && cmp_idx == rd_idx[5*p +: 5])
        oper_data[p*XLEN +: XLEN] = cmplt_data;
      else if (wb_fwd_en && wb_fwd_idx == rd_idx[5*p +: 5])
        oper_data[p*XLEN +: XLEN] = wb_fwd_data;
      else
        oper_data[p*XLEN +: XLEN] = gpr_rd_data[p*XLEN +: XLEN];
    end
  end

  always_comb begin
    vld_d = vld_q & ~cmp_hit;
    idx_d = idx_q;
    err_d = err_q || (cmplt_vld && !cmp_any);
    cnt_d = '0;
    for (int e = 0; e < NUM_PEND; e++) begin
      if (alloc && free_tag == TAGW'(e)) begin
        vld_d[e] = 1'b1;
        idx_d[e] = iss_dst;
      end
      cnt_d = cnt_d + (TAGW+1)'(vld_d[e]);
    end
  end

  always_ff @(posedge forever_cpuclk or negedge iu_yy_xx_reg_rst_b) begin
    if (!iu_yy_xx_reg_rst_b) begin
      vld_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign sb_pend_cnt = cnt_q;
  assign sb_err      = err_q;

endmodule

// File: tb/tb_cr_iu_oper_sb.sv
// Directed + random bench for cr_iu_oper_sb against a pending-list
// reference model of the scoreboard and operand priority rules.
module tb_cr_iu_oper_sb;
  localparam int NUM_RD   = 2;
  localparam int NUM_PEND = 2;
  localparam int XLEN     = 32;
  localparam int TAGW     = 3;

  logic                   clk;
  logic                   rst_b;
  logic [NUM_RD*5-1:0]    rd_idx;
  logic [NUM_RD*XLEN-1:0] gpr_rd_data;
  logic                   had_wbbr_vld;
  logic [XLEN-1:0]        had_wbbr_data;
  logic                   wb_fwd_en;
  logic [4:0]             wb_fwd_idx;
  logic [XLEN-1:0]        wb_fwd_data;
  logic                   iss_vld;
  logic                   iss_long;
  logic [4:0]             iss_dst;
  logic [NUM_RD-1:0]      iss_src_use;
  logic                   iss_rdy;
  logic [TAGW-1:0]        iss_tag;
  logic                   cmplt_vld;
  logic [TAGW-1:0]        cmplt_tag;
  logic [XLEN-1:0]        cmplt_data;
  logic [NUM_RD*XLEN-1:0] oper_data;
  logic [TAGW:0]          sb_pend_cnt;
  logic                   sb_err;

  int n_cmp = 0;
  int n_err = 0;

  bit         m_vld [NUM_PEND];
  logic [4:0] m_idx [NUM_PEND];
  bit         m_err;

  cr_iu_oper_sb #(
    .NUM_RD(NUM_RD), .NUM_PEND(NUM_PEND),
    .XLEN(XLEN), .TAGW(TAGW)
  ) dut (
    .forever_cpuclk     (clk),
    .iu_yy_xx_reg_rst_b (rst_b),
    .rd_idx             (rd_idx),
    .gpr_rd_data        (gpr_rd_data),
    .had_wbbr_vld       (had_wbbr_vld),
    .had_wbbr_data      (had_wbbr_data),
    .wb_fwd_en          (wb_fwd_en),
    .wb_fwd_idx         (wb_fwd_idx),
    .wb_fwd_data        (wb_fwd_data),
    .iss_vld            (iss_vld),
    .iss_long           (iss_long),
    .iss_dst            (iss_dst),
    .iss_src_use        (iss_src_use),
    .iss_rdy            (iss_rdy),
    .iss_tag            (iss_tag),
    .cmplt_vld          (cmplt_vld),
    .cmplt_tag          (cmplt_tag),
    .cmplt_data         (cmplt_data),
    .oper_data          (oper_data),
    .sb_pend_cnt        (sb_pend_cnt),
    .sb_err             (sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_completing(int e);
    return cmplt_vld && int'(cmplt_tag) == e && m_vld[e];
  endfunction

  function automatic bit m_pending(logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int e = 0; e < NUM_PEND; e++)
      if (m_vld[e] && m_idx[e] == r && !m_completing(e))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    for (int e = 0; e < NUM_PEND; e++)
      if (!m_vld[e]) return e;
    return -1;
  endfunction

  function automatic bit m_rdy();
    bit blk = 1'b0;
    for (int p = 0; p < NUM_RD; p++)
      if (iss_src_use[p] && m_pending(rd_idx[5*p +: 5])) blk = 1'b1;
    if (m_pending(iss_dst)) blk = 1'b1;
    if (iss_long && m_free() < 0) blk = 1'b1;
    return !blk;
  endfunction

  function automatic logic [31:0] m_oper(int p);
    logic [4:0] r;
    r = rd_idx[5*p +: 5];
    if (r == 5'd0) return 32'd0;
    if (had_wbbr_vld) return had_wbbr_data;
    for (int e = 0; e < NUM_PEND; e++)
      if (m_completing(e) && m_idx[e] == r) return cmplt_data;
    if (wb_fwd_en && wb_fwd_idx == r) return wb_fwd_data;
    return gpr_rd_data[p*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] m_cnt();
    int c = 0;
    for (int e = 0; e < NUM_PEND; e++) c += int'(m_vld[e]);
    return 32'(c);
  endfunction

  function automatic logic [31:0] m_tag();
    if (iss_vld && iss_long && m_rdy()) return 32'(m_free());
    return 32'd0;
  endfunction

  task automatic m_reset();
    for (int e = 0; e < NUM_PEND; e++) begin
      m_vld[e] = 1'b0;
      m_idx[e] = 5'd0;
    end
    m_err = 1'b0;
  endtask

  task automatic m_step();
    bit al;
    int a;
    int t;
    al = iss_vld && iss_long && m_rdy();
    a  = m_free();
    if (cmplt_vld) begin
      t = int'(cmplt_tag);
      if (t < NUM_PEND && m_vld[t]) m_vld[t] = 1'b0;
      else m_err = 1'b1;
    end
    if (al) begin
      m_vld[a] = 1'b1;
      m_idx[a] = iss_dst;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NUM_RD; p++)
      chk($sformatf("oper%0d", p), oper_data[p*XLEN +: XLEN], m_oper(p));
    chk("rdy", 32'(iss_rdy), 32'(m_rdy()));
    chk("tag", 32'(iss_tag), m_tag());
    chk("cnt", 32'(sb_pend_cnt), m_cnt());
    chk("err", 32'(sb_err), 32'(m_err));
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cyc();
    check_all();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rd_idx        = '0;
    gpr_rd_data   = '0;
    had_wbbr_vld  = 1'b0;
    had_wbbr_data = '0;
    wb_fwd_en     = 1'b0;
    wb_fwd_idx    = '0;
    wb_fwd_data   = '0;
    iss_vld       = 1'b0;
    iss_long      = 1'b0;
    iss_dst       = '0;
    iss_src_use   = '0;
    cmplt_vld     = 1'b0;
    cmplt_tag     = '0;
    cmplt_data    = '0;
  endtask

  task automatic issue(input logic lng, input logic [4:0] dst,
                       input logic [NUM_RD-1:0] use_m);
    iss_vld     = 1'b1;
    iss_long    = lng;
    iss_dst     = dst;
    iss_src_use = use_m;
  endtask

  task automatic cmplt(input logic v, input logic [TAGW-1:0] t,
                       input logic [31:0] d);
    cmplt_vld  = v;
    cmplt_tag  = t;
    cmplt_data = d;
  endtask

  initial begin
    quiet();
    m_reset();
    rst_b = 1'b0;
    #12;
    chk("rst_cnt", 32'(sb_pend_cnt), 32'd0);
    chk("rst_err", 32'(sb_err), 32'd0);
    chk("rst_tag", 32'(iss_tag), 32'd0);
    chk("rst_rdy", 32'(iss_rdy), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Plain GPR read
    rd_idx      = {5'd5, 5'd3};
    gpr_rd_data = {32'h22, 32'h11};
    iss_src_use = 2'b11;
    settle();
    chk("gpr0", oper_data[31:0], 32'h11);
    chk("gpr1", oper_data[63:32], 32'h22);
    chk("gpr_rdy", 32'(iss_rdy), 32'd1);
    cyc();

    // Long dst x7, dependent read, completion forward
    quiet();
    issue(1'b1, 5'd7, 2'b00);
    settle();
    chk("lng_tag", 32'(iss_tag), 32'd0);
    cyc();
    quiet();
    rd_idx = {5'd0, 5'd7};
    gpr_rd_data = {32'h0, 32'h1234};
    issue(1'b0, 5'd1, 2'b01);
    settle();
    chk("dep_rdy", 32'(iss_rdy), 32'd0);
    chk("dep_cnt", 32'(sb_pend_cnt), 32'd1);
    cyc();
    cmplt(1'b1, 3'd0, 32'hDEADBEEF);
    settle();
    chk("cf_rdy", 32'(iss_rdy), 32'd1);
    chk("cf_oper", oper_data[31:0], 32'hDEADBEEF);
    cyc();
    quiet();
    settle();
    chk("cf_cnt", 32'(sb_pend_cnt), 32'd0);
    cyc();

    // Fill, full block, freed entry not reused same cycle
    issue(1'b1, 5'd10, 2'b00);
    settle();
    chk("f_tag0", 32'(iss_tag), 32'd0);
    cyc();
    issue(1'b1, 5'd11, 2'b00);
    settle();
    chk("f_tag1", 32'(iss_tag), 32'd1);
    cyc();
    issue(1'b1, 5'd12, 2'b00);
    settle();
    chk("full_rdy", 32'(iss_rdy), 32'd0);
    chk("full_cnt", 32'(sb_pend_cnt), 32'd2);
    cmplt(1'b1, 3'd1, 32'h77);
    settle();
    chk("full_cmp_rdy", 32'(iss_rdy), 32'd0);
    cyc();
    cmplt(1'b0, 3'd0, 32'h0);
    settle();
    chk("reuse_rdy", 32'(iss_rdy), 32'd1);
    chk("reuse_tag", 32'(iss_tag), 32'd1);
    cyc();
    quiet();
    cmplt(1'b1, 3'd0, 32'h0);
    settle();
    cyc();
    cmplt(1'b1, 3'd1, 32'h0);
    settle();
    cyc();
    quiet();

    // Debug override beats WB forward; x0 reads zero
    rd_idx        = {5'd0, 5'd4};
    gpr_rd_data   = {32'h99, 32'h88};
    wb_fwd_en     = 1'b1;
    wb_fwd_idx    = 5'd4;
    wb_fwd_data   = 32'hA5;
    had_wbbr_vld  = 1'b1;
    had_wbbr_data = 32'h5A;
    settle();
    chk("had_oper", oper_data[31:0], 32'h5A);
    chk("x0_oper", oper_data[63:32], 32'h0);
    cyc();
    had_wbbr_vld = 1'b0;
    settle();
    chk("wbf_oper", oper_data[31:0], 32'hA5);
    cyc();
    quiet();

    // WAW block until completion
    issue(1'b1, 5'd9, 2'b00);
    settle();
    cyc();
    issue(1'b0, 5'd9, 2'b00);
    settle();
    chk("waw_rdy0", 32'(iss_rdy), 32'd0);
    cyc();
    settle();
    chk("waw_rdy1", 32'(iss_rdy), 32'd0);
    cyc();
    cmplt(1'b1, 3'd0, 32'h5);
    settle();
    chk("waw_rel", 32'(iss_rdy), 32'd1);
    cyc();
    quiet();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_idx[5*p +: 5] = 5'($urandom_range(0, 7));
        gpr_rd_data[p*XLEN +: XLEN] = $urandom;
      end
      had_wbbr_vld  = ($urandom_range(0, 7) == 0);
      had_wbbr_data = $urandom;
      wb_fwd_en     = 1'($urandom);
      wb_fwd_idx    = 5'($urandom_range(0, 7));
      wb_fwd_data   = $urandom;
      iss_vld       = 1'($urandom);
      iss_long      = 1'($urandom);
      iss_dst       = 5'($urandom_range(0, 7));
      iss_src_use   = NUM_RD'($urandom);
      cmplt_vld     = ($urandom_range(0, 2) == 0);
      cmplt_tag     = TAGW'($urandom_range(0, NUM_PEND));
      cmplt_data    = $urandom;
      settle();
      cyc();
    end

    // Drain, then reset with issue and completion in flight
    quiet();
    for (int e = 0; e < NUM_PEND; e++) begin
      if (m_vld[e]) begin
        cmplt(1'b1, TAGW'(e), 32'h0);
        settle();
        cyc();
      end
    end
    quiet();
    issue(1'b1, 5'd6, 2'b00);
    settle();
    chk("pre_rst_tag", 32'(iss_tag), 32'd0);
    cyc();
    issue(1'b1, 5'd8, 2'b00);
    cmplt(1'b1, 3'd0, 32'h3);
    settle();
    #1;
    rst_b = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_cnt", 32'(sb_pend_cnt), 32'd0);
    chk("mid_rst_err", 32'(sb_err), 32'd0);
    check_all();
    quiet();
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Completion to a pre-reset tag is an error and sticks
    cmplt(1'b1, 3'd0, 32'h0);
    settle();
    chk("old_tag_err0", 32'(sb_err), 32'd0);
    cyc();
    cmplt(1'b1, 3'd1, 32'h0);
    settle();
    chk("err_set", 32'(sb_err), 32'd1);
    cyc();
    quiet();
    settle();
    chk("err_stick", 32'(sb_err), 32'd1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
